// File: rtl/garden_pkg.sv
// Shared types for the garden zone sequencer.
// State encoding, duration table and display helpers.
package garden_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] DUR_00 = 4'd2;
  localparam logic [3:0] DUR_01 = 4'd4;
  localparam logic [3:0] DUR_10 = 4'd6;
  localparam logic [3:0] DUR_11 = 4'd9;

  localparam logic [1:0] LAST_ZONE = 2'd3;

  function automatic logic [3:0] dur_of(input logic [1:0] sel);
    logic [3:0] d;
    unique case (sel)
      2'b00:   d = DUR_00;
      2'b01:   d = DUR_01;
      2'b10:   d = DUR_10;
      default: d = DUR_11;
    endcase
    return d;
  endfunction

  function automatic logic [9:0] thermo(input logic [3:0] n);
    logic [9:0] t;
    t = '0;
    for (int i = 0; i < 10; i++) begin
      t[i] = (4'(i) < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/zone_sequencer_if.sv
// Pin bundle of the zone sequencer.
// The controller side drives the button and switch.
interface zone_sequencer_if;
  logic       start_button;
  logic [1:0] switch;
  logic [3:0] valve;
  logic [9:0] led_out;
  logic [3:0] ssm;
  logic       busy;
  logic       done;

  modport master (
    output start_button, switch,
    input  valve, led_out, ssm, busy, done
  );

  modport slave (
    input  start_button, switch,
    output valve, led_out, ssm, busy, done
  );
endinterface

// File: rtl/zone_sequencer_tick_gen.sv
// One-second prescaler for the zone sequencer.
// Counts 0..TICK_DIV-1 while enabled, pulses tick on the last count.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // next count: clear wins, otherwise wrap after the last count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/zone_sequencer.sv
// Four-zone sprinkler sequencer.
// Opens each zone in turn for the selected time, with one-second gaps.
module zone_sequencer
  import garden_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_button,
  input  logic [1:0] switch,
  output logic [3:0] valve,
  output logic [9:0] led_out,
  output logic [3:0] ssm,
  output logic       busy,
  output logic       done
);

  logic       sync1_q, sync2_q, sync3_q;
  state_t     state_q, state_d;
  logic [1:0] zone_q, zone_d;
  logic [3:0] remain_q, remain_d;
  logic [1:0] dur_q, dur_d;
  logic       press;
  logic       start;
  logic       tick;

  assign press = sync2_q & ~sync3_q;
  assign start = press && (state_q == IDLE);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (start),
    .tick (tick)
  );

  // button synchroniser and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= start_button;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // next state: a press aborts a run, except in DONE
  always_comb begin
    state_d  = state_q;
    zone_d   = zone_q;
    remain_d = remain_q;
    dur_d    = dur_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d  = OPEN;
          zone_d   = 2'd0;
          dur_d    = switch;
          remain_d = dur_of(switch);
        end
      end
      OPEN: begin
        if (press) begin
          state_d  = IDLE;
          zone_d   = 2'd0;
          remain_d = 4'd0;
        end else if (tick) begin
          if (remain_q > 4'd1) begin
            remain_d = remain_q - 4'd1;
          end else if (zone_q != LAST_ZONE) begin
            state_d = GAP;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (press) begin
          state_d  = IDLE;
          zone_d   = 2'd0;
          remain_d = 4'd0;
        end else if (tick) begin
          state_d  = OPEN;
          zone_d   = zone_q + 2'd1;
          remain_d = dur_of(dur_q);
        end
      end
      default: begin
        state_d  = IDLE;
        zone_d   = 2'd0;
        remain_d = 4'd0;
      end
    endcase
  end

  // sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      zone_q   <= 2'd0;
      remain_q <= 4'd0;
      dur_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      zone_q   <= zone_d;
      remain_q <= remain_d;
      dur_q    <= dur_d;
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    valve   = 4'd0;
    led_out = 10'd0;
    ssm     = 4'd0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    if (state_q == OPEN) begin
      valve   = 4'b0001 << zone_q;
      led_out = thermo(remain_q);
      ssm     = remain_q;
    end
  end

endmodule

// File: tb/tb_zone_sequencer.sv
// Bench for zone_sequencer with TICK_DIV=4.
// Timeline-based reference model, directed scenarios then random stimulus.
module tb_zone_sequencer;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  zone_sequencer_if zif ();

  zone_sequencer #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_button (zif.start_button),
    .switch       (zif.switch),
    .valve        (zif.valve),
    .led_out      (zif.led_out),
    .ssm          (zif.ssm),
    .busy         (zif.busy),
    .done         (zif.done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int DUR [4] = '{2, 4, 6, 9};

  int cyc   = 0;
  bit hist [0:19999];
  int m_r   = 0;
  bit m_run = 1'b0;
  int m_t0  = 0;
  int m_dur = 2;

  // expected {valve, led_out, ssm, busy, done} k cycles after a run started
  function automatic logic [19:0] model_out(bit run, int dur, int k);
    int total, seg, z, off, rem;
    logic [3:0] v;
    logic [9:0] l;
    if (!run) return 20'd0;
    total = 4 * dur * TD + 3 * TD;
    if (k == total) return 20'd3;
    seg = (dur + 1) * TD;
    z   = k / seg;
    off = k % seg;
    if (off >= dur * TD) return 20'd2;
    rem = dur - off / TD;
    v = 4'(1 << z);
    l = 10'((1 << rem) - 1);
    return {v, l, 4'(rem), 1'b1, 1'b0};
  endfunction

  task automatic step();
    int n, kp;
    bit b2, b3, prs;
    logic [19:0] obs, expv;
    @(posedge clk);
    cyc = cyc + 1;
    n = cyc;
    hist[n] = zif.start_button;
    if (rst) begin
      m_run = 1'b0;
      m_r   = n;
    end else begin
      b2  = (n - 2 > m_r) ? hist[n-2] : 1'b0;
      b3  = (n - 3 > m_r) ? hist[n-3] : 1'b0;
      prs = b2 && !b3;
      kp  = n - 1 - m_t0;
      if (m_run && kp == 4 * m_dur * TD + 3 * TD) begin
        m_run = 1'b0;
      end else if (prs) begin
        if (m_run) begin
          m_run = 1'b0;
        end else begin
          m_run = 1'b1;
          m_t0  = n;
          m_dur = DUR[zif.switch];
        end
      end
    end
    #1;
    expv = model_out(m_run, m_dur, n - m_t0);
    obs  = {zif.valve, zif.led_out, zif.ssm, zif.busy, zif.done};
    vectors = vectors + 1;
    assert (obs === expv) else begin
      miscompares = miscompares + 1;
      $error("FAIL outputs cyc=%0d observed=%h expected=%h", n, obs, expv);
    end
  endtask

  task automatic steps(int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic press();
    zif.start_button = 1'b1;
    steps(3);
    zif.start_button = 1'b0;
  endtask

  initial begin
    zif.start_button = 1'b0;
    zif.switch       = 2'b00;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(3);

    zif.switch = 2'b00;
    press();
    steps(60);

    zif.switch = 2'b11;
    press();
    steps(170);

    zif.switch = 2'b01;
    press();
    steps(20);
    zif.switch = 2'b11;
    steps(90);

    zif.switch = 2'b00;
    press();
    steps(25);
    zif.start_button = 1'b1;
    steps(5);
    zif.start_button = 1'b0;
    steps(60);

    zif.switch = 2'b00;
    press();
    steps(21);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(3);
    press();
    steps(60);

    zif.switch = 2'b00;
    zif.start_button = 1'b1;
    steps(200);
    zif.start_button = 1'b0;
    steps(20);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) begin
        zif.start_button = ~zif.start_button;
      end
      zif.switch = 2'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0;
    zif.start_button = 1'b0;
    steps(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
